// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants and types for the serial FIR MAC filter.
//               Holds the default parameter values and the control-state
//               encoding used by fir_mac_serial.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int c_DATA_W_DEF = 16;
    localparam int c_COEF_W_DEF = 16;
    localparam int c_NTAPS_DEF  = 123;
    localparam int c_FRAC_DEF   = 14;
    localparam int c_OUT_W_DEF  = 17;

    // IDLE : waiting for a sample (in_ready high)
    // MAC  : one multiply-accumulate per cycle
    // HOLD : result presented until consumed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } fir_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_bank
// Description : Coefficient store for the serial FIR. One synchronous write
//               port (writes to addresses >= NTAPS are dropped) and one
//               combinational read port indexed by the tap counter.
//               The bank has no reset; its contents survive rst.
// Ports       : clk              - clock
//               i_we             - write strobe (already gated by caller)
//               i_waddr/i_wdata  - write address / data
//               i_raddr          - read address (tap index k)
//               o_rdata          - coefficient h[k]
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_bank #(
    parameter int COEF_W = 16,
    parameter int NTAPS  = 123,
    parameter int AW     = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_waddr,
    input  logic signed [COEF_W-1:0] i_wdata,
    input  logic [AW-1:0]            i_raddr,
    output logic signed [COEF_W-1:0] o_rdata
);

    localparam logic [AW:0] c_NTAPS = (AW+1)'(NTAPS);

    logic signed [COEF_W-1:0] r_mem [NTAPS];
    logic                     w_wr;

    assign w_wr = i_we && ({1'b0, i_waddr} < c_NTAPS);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fir_mac_serial.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_serial
// Description : Time-shared single-multiplier FIR filter. Each accepted
//               sample triggers NTAPS multiply-accumulate steps over a
//               circular delay line, then the scaled result is held until
//               consumed.
//               Build option: define FIR_OUT_SAT_EN to saturate the output
//               to OUT_W bits; otherwise the output wraps (low OUT_W bits).
// Ports       : clk, rst                  - clock, sync active-high reset
//               in_valid/in_ready/in_data - sample input handshake
//               coef_we/coef_addr/coef_data - coefficient write port
//               out_valid/out_ready/out_data - result output handshake
//               busy                      - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_serial
    import fir_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int COEF_W = c_COEF_W_DEF,
    parameter int NTAPS  = c_NTAPS_DEF,
    parameter int FRAC   = c_FRAC_DEF,
    parameter int OUT_W  = c_OUT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    in_data,
    input  logic                        coef_we,
    input  logic [$clog2(NTAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_data,
    output logic                        busy
);

    localparam int c_AW     = $clog2(NTAPS);
    localparam int c_KW     = $clog2(NTAPS + 1);
    localparam int c_PROD_W = DATA_W + COEF_W;
    localparam int c_ACC_W  = DATA_W + COEF_W + c_AW;

    localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(NTAPS - 1);
    localparam logic [c_KW-1:0] c_K_LAST   = c_KW'(NTAPS);

    fir_state_t                  r_state;
    logic [c_AW-1:0]             r_wptr;
    logic [c_AW-1:0]             r_rptr;
    logic [c_KW-1:0]             r_k;
    logic signed [c_PROD_W-1:0]  r_prod;
    logic signed [c_ACC_W-1:0]   r_acc;
    logic signed [OUT_W-1:0]     r_out;
    logic                        r_out_valid;
    logic signed [DATA_W-1:0]    r_dly [NTAPS];

    logic                        w_accept;
    logic                        w_coef_we;
    logic signed [DATA_W-1:0]    w_x;
    logic signed [COEF_W-1:0]    w_h;
    logic signed [c_PROD_W-1:0]  w_prod;
    logic signed [c_ACC_W-1:0]   w_acc_sum;
    logic signed [OUT_W-1:0]     w_out;
    logic [c_AW-1:0]             w_wptr_next;
    logic [c_AW-1:0]             w_rptr_prev;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_coef_we = coef_we && (r_state == IDLE);

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .AW     (c_AW)
    ) u_coef_bank (
        .clk     (clk),
        .i_we    (w_coef_we),
        .i_waddr (coef_addr),
        .i_wdata (coef_data),
        .i_raddr (r_k[c_AW-1:0]),
        .o_rdata (w_h)
    );

    assign w_wptr_next = (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_AW'(1);
    assign w_rptr_prev = (r_rptr == '0) ? c_PTR_LAST : r_rptr - c_AW'(1);

    // The read pointer starts at the slot holding x[n] and walks backwards,
    // so step k reads x[n-k].
    assign w_x       = r_dly[r_rptr];
    assign w_prod    = c_PROD_W'(w_x) * c_PROD_W'(w_h);
    assign w_acc_sum = r_acc + c_ACC_W'(r_prod);

`ifdef FIR_OUT_SAT_EN
    logic signed [c_ACC_W-1:0]   w_shift;
    logic [c_ACC_W-OUT_W:0]      w_hi;
    assign w_shift = w_acc_sum >>> FRAC;
    // In range exactly when the bits above the output sign bit are all
    // copies of it.
    assign w_hi    = w_shift[c_ACC_W-1:OUT_W-1];
    always_comb begin
        w_out = w_shift[OUT_W-1:0];
        if (!((&w_hi) || (~|w_hi))) begin
            w_out = w_shift[c_ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign w_out = OUT_W'(w_acc_sum >>> FRAC);
`endif

    // Delay line: cleared on reset so unwritten taps read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_dly[i] <= '0;
            end
        end else if (w_accept) begin
            r_dly[r_wptr] <= in_data;
        end
    end

    // Control and datapath. The product is registered, so MAC runs
    // NTAPS+1 cycles: step k issues product k, step k+1 accumulates it,
    // and the final step folds the last product straight into the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_k         <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wptr  <= w_wptr_next;
                        r_rptr  <= r_wptr;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    if (r_k != c_K_LAST) begin
                        r_prod <= w_prod;
                        r_rptr <= w_rptr_prev;
                    end
                    if (r_k != '0) begin
                        r_acc <= w_acc_sum;
                    end
                    if (r_k == c_K_LAST) begin
                        r_out       <= w_out;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_serial
// Description : Self-checking bench for fir_mac_serial (NTAPS=8, FRAC=0,
//               OUT_W=17). Expected results come from a convolution model
//               over the full accepted-sample history and are queued at
//               accept time; a monitor pops and compares on each output
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_serial;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int NTAPS  = 8;
    localparam int FRAC   = 0;
    localparam int OUT_W  = 17;
    localparam int AW     = $clog2(NTAPS);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;

    fir_mac_serial #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .FRAC   (FRAC),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint h_m [NTAPS];
    longint hist[$];
    longint exp_q[$];
    int     acc_t_q[$];
    logic   prev_ov = 1'b0;
    bit     rand_rdy = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Scale and fit the accumulator value to OUT_W the way the output does.
    function automatic longint fit_out(input longint acc);
        longint s;
        longint lim;
        lim = longint'(1) << (OUT_W - 1);
        s   = acc >>> FRAC;
`ifdef FIR_OUT_SAT_EN
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
`else
        s = s & ((lim << 1) - 1);
        if (s >= lim) s = s - (lim << 1);
`endif
        return s;
    endfunction

    // y[n] = sum_k x[n-k]*h[k], samples older than reset are zero.
    function automatic longint model_out();
        longint sum = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (hist.size() - 1 - k >= 0) sum += hist[hist.size() - 1 - k] * h_m[k];
        end
        return fit_out(sum);
    endfunction

    // Monitor: latency on each new result, data on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (acc_t_q.size() > 0) check("latency", longint'(cyc - acc_t_q.pop_front()), NTAPS + 1);
                else check("spurious out_valid", longint'(out_valid), 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) check("out_data", longint'(out_data), exp_q.pop_front());
                else check("unexpected output", longint'(out_valid), 0);
            end
        end
        prev_ov <= out_valid;
    end

    // Each wait loop runs in the phase 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ready(output bit ok);
        int g = 0;
        ok = 1'b1;
        while (!in_ready) begin
            step();
            g++;
            if (g > 200) begin
                timeout("wait in_ready");
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic write_coef(input int addr, input longint val);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = COEF_W'(val);
        step();
        coef_we   = 1'b0;
        h_m[addr] = longint'(signed'(COEF_W'(val)));
    endtask

    task automatic send(input longint d, input bit use_req, input longint req,
                        input bit with_coef, input int caddr, input longint cval);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        if (with_coef) begin
            coef_we   = 1'b1;
            coef_addr = AW'(caddr);
            coef_data = COEF_W'(cval);
        end
        step();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (with_coef) h_m[caddr] = longint'(signed'(COEF_W'(cval)));
        hist.push_back(longint'(signed'(DATA_W'(d))));
        exp_q.push_back(use_req ? req : model_out());
        acc_t_q.push_back(cyc);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 || !in_ready) begin
            step();
            g++;
            if (g > 500) begin
                timeout("drain");
                exp_q.delete();
                acc_t_q.delete();
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        exp_q.delete();
        acc_t_q.delete();
        hist.delete();
        rst = 1'b0;
        check("reset in_ready", longint'(in_ready), 1);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset busy", longint'(busy), 0);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    endtask

    task automatic impulse(input string tag);
        longint req [10];
        req = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
        for (int i = 0; i < 10; i++) send((i == 0) ? 1 : 0, 1'b1, req[i], 1'b0, 0, 0);
        drain();
    endtask

    initial begin
        bit     seen;
        int     g;
        logic signed [15:0] r16;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
        for (int k = 0; k < NTAPS; k++) h_m[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_data", longint'(out_data), 0);
        rst = 1'b0;
        step();
        check("idle in_ready", longint'(in_ready), 1);
        check("idle busy", longint'(busy), 0);

        // Impulse response
        load_ramp();
        impulse("impulse");

        // Latency and backpressure
        out_ready = 1'b0;
        send(5, 1'b0, 0, 1'b0, 0, 0);
        g = 0;
        while (!out_valid && g < 100) begin step(); g++; end
        if (!out_valid) timeout("wait out_valid");
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold out_valid", longint'(out_valid), 1);
            if (exp_q.size() > 0) check("hold out_data", longint'(out_data), exp_q[0]);
            check("hold in_ready", longint'(in_ready), 0);
            check("hold busy", longint'(busy), 1);
        end
        out_ready = 1'b1;
        step();
        check("release out_valid", longint'(out_valid), 0);
        check("release in_ready", longint'(in_ready), 1);
        drain();

        // Coefficient write during MAC is ignored
        send(3, 1'b0, 0, 1'b0, 0, 0);
        step(); step();
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd100;
        step();
        coef_we = 1'b0;
        drain();
        // Same write in IDLE takes effect
        write_coef(0, 100);
        send(2, 1'b0, 0, 1'b0, 0, 0);
        // Write coinciding with accept: new coefficient is used
        send(-7, 1'b0, 0, 1'b1, 1, -50);
        drain();

        // Reset in the 3rd MAC cycle, coefficients retained
        load_ramp();
        drain();
        send(9, 1'b0, 0, 1'b0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete(); acc_t_q.delete(); hist.delete();
        check("abort in_ready", longint'(in_ready), 1);
        seen = 1'b0;
        repeat (NTAPS + 6) begin step(); if (out_valid) seen = 1'b1; end
        check("abort no out_valid", longint'(seen), 0);
        impulse("impulse after abort");

        // Saturation / wrap boundary
        do_reset();
        write_coef(0, 32767);
        for (int k = 1; k < NTAPS; k++) write_coef(k, 0);
`ifdef FIR_OUT_SAT_EN
        send(32767, 1'b1, 65535, 1'b0, 0, 0);
`else
        send(32767, 1'b1, -65535, 1'b0, 0, 0);
`endif
        drain();

        // Pointer wrap with random data and random backpressure
        do_reset();
        for (int k = 0; k < NTAPS; k++) begin
            r16 = 16'($urandom);
            write_coef(k, longint'(r16));
        end
        rand_rdy = 1'b1;
        for (int i = 0; i < 2 * NTAPS + 3; i++) begin
            r16 = 16'($urandom);
            send(longint'(r16), 1'b0, 0, 1'b0, 0, 0);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();
        check("scoreboard empty", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/fir_mac_serial.md
FIR_MAC_SERIAL -- requirements
Module: fir_mac_serial

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 16, signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 123, tap count, range 2..1024.
REQ-004 SHALL have parameter FRAC, default 14, fractional bits removed from the accumulator.
REQ-005 SHALL have parameter OUT_W, default 17, signed output width.
REQ-006 SHALL have clk, input, 1, single clock; all logic is on the rising edge.
REQ-007 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have in_valid, input, 1, sample offered.
REQ-009 SHALL have in_ready, output, 1, sample accepted when in_valid && in_ready.
REQ-010 SHALL have in_data, input, DATA_W, signed sample.
REQ-011 SHALL have coef_we, input, 1, coefficient write strobe.
REQ-012 SHALL have coef_addr, input, clog2(NTAPS), tap index.
REQ-013 SHALL have coef_data, input, COEF_W, signed coefficient.
REQ-014 SHALL have out_valid, output, 1, result present.
REQ-015 SHALL have out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-016 SHALL have out_data, output, OUT_W, signed filter result.
REQ-017 SHALL have busy, output, 1, high in any state except IDLE.

Function
REQ-018 SHALL use a single time-shared multiplier and accumulator, with states IDLE, MAC and HOLD.
REQ-019 SHALL drive in_ready=1 only in IDLE.
- On accept, the sample is written at the circular write pointer, the pointer advances mod NTAPS (wrap NTAPS-1 -> 0), the accumulator clears, and the state goes to MAC.
REQ-020 SHALL, in MAC, add one product per cycle for k=0..NTAPS-1: acc += x[n-k]*h[k].
- x[n] is the sample just accepted.
- Products are full precision.
- The accumulator width is DATA_W+COEF_W+clog2(NTAPS); it never overflows.
REQ-021 SHALL, after the k=NTAPS-1 product, go to HOLD and register out_data = acc >>> FRAC (arithmetic shift, truncation toward minus infinity), with out_valid=1.
REQ-022 SHALL fix latency: a sample accepted at edge T gives out_valid=1 after edge T+NTAPS+1.
REQ-023 SHALL hold out_valid and out_data stable in HOLD while out_ready=0.
- On out_ready=1, out_valid drops and the state goes to IDLE in the same edge.
- The next sample can be accepted at the following edge.
REQ-024 SHALL write coefficients only when coef_we=1 and state is IDLE.
- Writes in MAC or HOLD are ignored.
- Writes with coef_addr>=NTAPS are ignored.
REQ-025 SHALL let the coefficient write take precedence when it coincides with a sample accept in IDLE; the computation uses the new coefficient.
REQ-026 SHALL treat delay-line entries not yet written since reset as zero.

Reset
REQ-027 SHALL, on rst=1, force state IDLE, in_ready=1 on the following cycle, out_valid=0, out_data=0, busy=0, write pointer 0, accumulator 0, and all delay-line entries 0.
REQ-028 SHALL NOT alter the coefficient bank on reset; its power-up contents are all zero.
REQ-029 SHALL abort any MAC or HOLD in progress on rst asserted in that state; no out_valid is produced for the aborted sample.

Configuration
REQ-030 SHALL saturate out_data to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1] when FIR_OUT_SAT_EN is defined.
REQ-031 SHALL, when FIR_OUT_SAT_EN is not defined, set out_data to the low OUT_W bits of the shifted accumulator (two's-complement wrap) and instantiate no saturation logic.

Structure
REQ-032 SHALL place the default parameter constants and the state enum typedef (IDLE, MAC, HOLD) in shared package fir_pkg.
REQ-033 SHALL implement the coefficient bank as sub-module fir_coef_bank, with one write port and one combinational read port indexed by k.

Verification
REQ-034 SHALL cover impulse response.
- Setup: NTAPS=8, FRAC=0; load h[k]=k+1.
- Stimulus: input 1, then nine zeros.
- Required outputs: 1,2,3,4,5,6,7,8,0,0.
REQ-035 SHALL cover latency and backpressure.
- Accept at edge T gives out_valid after T+NTAPS+1.
- Hold out_ready=0 for 5 cycles: out_data stays constant, in_ready=0, busy=1.
REQ-036 SHALL cover the saturation/wrap boundary.
- Setup: FRAC=0, OUT_W=17, h[0]=32767, others 0; input 32767.
- With FIR_OUT_SAT_EN: 65535.
- Without FIR_OUT_SAT_EN: -65535.
REQ-037 SHALL cover coefficient gating: coef_we to h[0]=100 during MAC leaves the result unchanged, and the same write in IDLE affects the next output.
REQ-038 SHALL cover reset mid-operation.
- Stimulus: assert rst in the 3rd MAC cycle.
- Required: no out_valid, in_ready=1 after release, and the next impulse gives the REQ-034 sequence with the coefficients retained.
REQ-039 SHALL cover pointer wrap: feed 2*NTAPS+3 random samples and compare every output against a reference model.
